// File: rtl/count_scan_pkg.sv
// Shared types and switch bit positions for the counter/scan sequencing controller.
package count_scan_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      STEP  = 3'd4
   } state_t;

   localparam int SW_START = 0;
   localparam int SW_STEP  = 1;
   localparam int SW_SCAN  = 2;
   localparam int SW_LOAD  = 3;

endpackage

// File: rtl/swi_edge.sv
// Registers the switch bank every cycle and reports rising edges against the previous sample.
module swi_edge #(
   parameter int W = 8
) (
   input  logic         clk_2,
   input  logic         reset,
   input  logic [W-1:0] swi_i,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] prev_q;

   // Capturing during reset too means a switch held high through reset never reports an edge.
   always_ff @(posedge clk_2) begin
      prev_q <= swi_i;
   end

   assign rise_o = swi_i & ~prev_q & {W{~reset}};

endmodule

// File: rtl/count_scan_ctrl.sv
// Switch-driven load/run/pause/step controller for a modular counter, with a lookahead
// display selector that auto-scans and drives LED, SEG and the LCD fields.
module count_scan_ctrl
   import count_scan_pkg::*;
#(
   parameter int NBITS     = 4,
   parameter int NCOUNT    = 4,
   parameter int INCR      = 3,
   parameter int SCAN_DIV  = 4,
   parameter int NBITS_LCD = 64
) (
   input  logic                 clk_2,
   input  logic                 reset,
   input  logic [7:0]           SWI,
   output logic [7:0]           LED,
   output logic [7:0]           SEG,
   output logic [NBITS_LCD-1:0] lcd_a,
   output logic [NBITS_LCD-1:0] lcd_b,
   output logic [2:0]           dbg_state_o
);

   localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   state_t            state_q, state_d;
   logic [NBITS-1:0]  cnt_q, cnt_d;
   logic              wrap_q, wrap_d;
   logic [2:0]        sel_q, sel_d;
   logic [DIVW-1:0]   div_q, div_d;
   logic [7:0]        rise;
   logic [NBITS:0]    sum;
   logic [NBITS-1:0]  va [1:NCOUNT];
   logic [NBITS-1:0]  sel_val;
   logic [3:0]        cnt4;

   swi_edge #(.W(8)) u_edge (
      .clk_2  (clk_2),
      .reset  (reset),
      .swi_i  (SWI),
      .rise_o (rise)
   );

   // The extra top bit is the carry that feeds the sticky wrap flag.
   assign sum = {1'b0, cnt_q} + (NBITS+1)'(INCR);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wrap_d  = wrap_q;
      case (state_q)
         IDLE: begin
            if (rise[SW_LOAD])       state_d = LOAD;
            else if (rise[SW_START]) state_d = RUN;
         end
         LOAD: begin
            cnt_d   = NBITS'(SWI[7:4]);
            wrap_d  = 1'b0;
            state_d = PAUSE;
         end
         RUN: begin
            cnt_d  = sum[NBITS-1:0];
            wrap_d = wrap_q | sum[NBITS];
            if (rise[SW_LOAD])       state_d = LOAD;
            else if (rise[SW_START]) state_d = PAUSE;
         end
         PAUSE: begin
            if (rise[SW_LOAD])       state_d = LOAD;
            else if (rise[SW_START]) state_d = RUN;
            else if (rise[SW_STEP])  state_d = STEP;
         end
         STEP: begin
            cnt_d   = sum[NBITS-1:0];
            wrap_d  = wrap_q | sum[NBITS];
            state_d = PAUSE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_d = sel_q;
      div_d = div_q;
      if (SWI[SW_SCAN]) begin
         if (div_q == DIVW'(SCAN_DIV - 1)) begin
            div_d = '0;
            sel_d = (sel_q == 3'(NCOUNT)) ? 3'd0 : sel_q + 3'd1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end else begin
         sel_d = 3'd0;
         div_d = '0;
      end
   end

   always_comb begin
      for (int k = 1; k <= NCOUNT; k++) begin
         va[k] = NBITS'(int'(cnt_q) + k * INCR);
      end
   end

   // Selector values beyond NCOUNT show zero rather than aliasing a lookahead slot.
   always_comb begin
      sel_val = '0;
      if (sel_q == 3'd0) sel_val = cnt_q;
      for (int k = 1; k <= NCOUNT; k++) begin
         if (sel_q == 3'(k)) sel_val = va[k];
      end
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         sel_q   <= 3'd0;
         div_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         sel_q   <= sel_d;
         div_q   <= div_d;
      end
   end

   assign cnt4        = 4'(cnt_q);
   assign LED         = {cnt4, SWI[SW_SCAN], wrap_q,
                         (state_q == PAUSE) || (state_q == STEP), state_q == RUN};
   assign SEG         = {1'b0, sel_q, cnt4};
   assign lcd_a       = NBITS_LCD'(SWI[7:4]);
   assign lcd_b       = NBITS_LCD'(sel_val);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_count_scan_ctrl.sv
// Bench for count_scan_ctrl: cycle model feeding a scoreboard queue, plus directed sequence checks.
module tb_count_scan_ctrl;
   import count_scan_pkg::*;

   localparam int NBITS     = 4;
   localparam int NCOUNT    = 4;
   localparam int INCR      = 3;
   localparam int SCAN_DIV  = 2;
   localparam int NBITS_LCD = 64;
   localparam int W         = 3 + 8 + 8 + NBITS_LCD + NBITS_LCD;
   localparam int MODV      = 2 ** NBITS;

   logic                 clk_2 = 1'b0;
   logic                 reset = 1'b1;
   logic [7:0]           SWI   = 8'h09;
   logic [7:0]           LED;
   logic [7:0]           SEG;
   logic [NBITS_LCD-1:0] lcd_a;
   logic [NBITS_LCD-1:0] lcd_b;
   logic [2:0]           dbg_state;

   count_scan_ctrl #(
      .NBITS(NBITS), .NCOUNT(NCOUNT), .INCR(INCR),
      .SCAN_DIV(SCAN_DIV), .NBITS_LCD(NBITS_LCD)
   ) dut (
      .clk_2       (clk_2),
      .reset       (reset),
      .SWI         (SWI),
      .LED         (LED),
      .SEG         (SEG),
      .lcd_a       (lcd_a),
      .lcd_b       (lcd_b),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   always #5 clk_2 = ~clk_2;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];

   state_t     m_state = IDLE;
   int         m_cnt   = 0;
   int         m_sel   = 0;
   int         m_div   = 0;
   bit         m_wrap  = 1'b0;
   logic [7:0] m_prev  = 8'h00;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_inc();
      m_wrap = m_wrap | ((m_cnt + INCR) >= MODV);
      m_cnt  = (m_cnt + INCR) % MODV;
   endtask

   task automatic model_update(input logic [7:0] sw, input logic rst);
      logic [7:0] rise;
      if (rst) begin
         m_state = IDLE; m_cnt = 0; m_wrap = 0; m_sel = 0; m_div = 0; m_prev = sw;
      end else begin
         rise   = sw & ~m_prev;
         m_prev = sw;
         if (sw[2]) begin
            m_div++;
            if (m_div == SCAN_DIV) begin
               m_div = 0;
               m_sel = (m_sel + 1) % (NCOUNT + 1);
            end
         end else begin
            m_div = 0;
            m_sel = 0;
         end
         case (m_state)
            IDLE: begin
               if (rise[3])      m_state = LOAD;
               else if (rise[0]) m_state = RUN;
            end
            LOAD: begin
               m_cnt = int'(sw[7:4]); m_wrap = 0; m_state = PAUSE;
            end
            RUN: begin
               m_inc();
               if (rise[3])      m_state = LOAD;
               else if (rise[0]) m_state = PAUSE;
            end
            PAUSE: begin
               if (rise[3])      m_state = LOAD;
               else if (rise[0]) m_state = RUN;
               else if (rise[1]) m_state = STEP;
            end
            default: begin
               m_inc();
               m_state = PAUSE;
            end
         endcase
      end
   endtask

   function automatic logic [W-1:0] exp_word(input logic [7:0] sw);
      logic [7:0] led, seg;
      int         vb;
      led = {4'(m_cnt), sw[2], m_wrap, (m_state == PAUSE) || (m_state == STEP), m_state == RUN};
      seg = {1'b0, 3'(m_sel), 4'(m_cnt)};
      if (m_sel == 0)           vb = m_cnt;
      else if (m_sel <= NCOUNT) vb = (m_cnt + m_sel * INCR) % MODV;
      else                      vb = 0;
      return {3'(m_state), led, seg, NBITS_LCD'(sw[7:4]), NBITS_LCD'(vb)};
   endfunction

   // driver: one clock cycle with given inputs; scoreboard compares after the edge
   task automatic tick(input logic [7:0] sw, input logic rst);
      logic [W-1:0] e;
      SWI   = sw;
      reset = rst;
      @(posedge clk_2);
      model_update(sw, rst);
      exp_q.push_back(exp_word(sw));
      @(negedge clk_2);
      e = exp_q.pop_front();
      check_val("sb_state", 64'(dbg_state), 64'(e[W-1 -: 3]));
      check_val("sb_led",   64'(LED),       64'(e[W-4 -: 8]));
      check_val("sb_seg",   64'(SEG),       64'(e[W-12 -: 8]));
      check_val("sb_lcd_a", lcd_a,          e[2*NBITS_LCD-1 -: NBITS_LCD]);
      check_val("sb_lcd_b", lcd_b,          e[NBITS_LCD-1:0]);
   endtask

   initial begin
      int  run_seq [4];
      int  scan_seq [11];
      bit  found;
      run_seq  = '{8, 11, 14, 1};
      scan_seq = '{5, 8, 8, 11, 11, 14, 14, 1, 1, 5, 5};

      // reset with load+start held high: no edge after release
      for (int i = 0; i < 3; i++) tick(8'h09, 1'b1);
      for (int i = 0; i < 2; i++) tick(8'h09, 1'b0);
      check_val("rst_state", 64'(dbg_state), 64'(IDLE));
      check_val("rst_led",   64'(LED), 64'h0);
      check_val("rst_seg",   64'(SEG), 64'h0);
      check_val("rst_lcd_b", lcd_b,    64'h0);

      // load 5, run through a wrap
      tick(8'h50, 1'b0);
      tick(8'h58, 1'b0);
      check_val("load_state", 64'(dbg_state), 64'(LOAD));
      tick(8'h50, 1'b0);
      check_val("load_cnt", 64'(LED[7:4]), 64'd5);
      check_val("load_pause", 64'(dbg_state), 64'(PAUSE));
      tick(8'h51, 1'b0);
      check_val("run_cnt0", 64'(LED[7:4]), 64'd5);
      for (int i = 0; i < 4; i++) begin
         tick(8'h51, 1'b0);
         check_val("run_cnt", 64'(LED[7:4]), 64'(run_seq[i]));
         check_val("run_wrap", 64'(LED[2]), (i == 3) ? 64'd1 : 64'd0);
      end
      tick(8'h59, 1'b0);
      tick(8'h51, 1'b0);
      check_val("reload_wrap", 64'(LED[2]), 64'd0);
      check_val("reload_cnt",  64'(LED[7:4]), 64'd5);

      // single step from 7, held step switch gives no more steps
      tick(8'h70, 1'b0);
      tick(8'h78, 1'b0);
      tick(8'h70, 1'b0);
      check_val("pre_step_cnt", 64'(LED[7:4]), 64'd7);
      tick(8'h72, 1'b0);
      check_val("step_state", 64'(dbg_state), 64'(STEP));
      tick(8'h72, 1'b0);
      check_val("step_cnt",   64'(LED[7:4]), 64'd10);
      check_val("step_pause", 64'(dbg_state), 64'(PAUSE));
      tick(8'h72, 1'b0);
      tick(8'h72, 1'b0);
      check_val("step_hold_cnt", 64'(LED[7:4]), 64'd10);

      // load, start and step edges together from RUN: load wins
      tick(8'h70, 1'b0);
      tick(8'h71, 1'b0);
      check_val("run_again", 64'(dbg_state), 64'(RUN));
      tick(8'h70, 1'b0);
      tick(8'h3B, 1'b0);
      check_val("prio_state", 64'(dbg_state), 64'(LOAD));
      tick(8'h30, 1'b0);
      check_val("prio_cnt", 64'(LED[7:4]), 64'd3);

      // scan with counter paused at 5
      tick(8'h50, 1'b0);
      tick(8'h58, 1'b0);
      tick(8'h50, 1'b0);
      for (int i = 0; i < 11; i++) begin
         tick(8'h54, 1'b0);
         check_val("scan_lcd_b", lcd_b, 64'(scan_seq[i]));
      end
      tick(8'h54, 1'b0);
      check_val("scan_sel1", 64'(SEG[6:4]), 64'd1);
      tick(8'h50, 1'b0);
      check_val("scan_off_sel", 64'(SEG[6:4]), 64'd0);
      check_val("scan_off_lcd", lcd_b, 64'd5);

      // run (scan on) until counter 14 with wrap set, then reset for one cycle
      tick(8'h55, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (m_state == RUN && m_cnt == 14 && m_wrap) begin
            found = 1'b1;
            break;
         end
         tick(8'h55, 1'b0);
      end
      check_val("reach_14", 64'(found), 64'd1);
      check_val("pre_rst_cnt", 64'(LED[7:4]), 64'd14);
      tick(8'h55, 1'b1);
      check_val("mid_rst_state", 64'(dbg_state), 64'(IDLE));
      check_val("mid_rst_cnt",   64'(LED[7:4]), 64'd0);
      check_val("mid_rst_wrap",  64'(LED[2]), 64'd0);
      check_val("mid_rst_sel",   64'(SEG[6:4]), 64'd0);
      tick(8'h55, 1'b0);
      check_val("post_rst_idle", 64'(dbg_state), 64'(IDLE));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
